// File: rtl/mnist_pkg.sv
// Shared types and default sizes for the MNIST classification pipeline.
package mnist_pkg;

  localparam int DEF_BIT_WIDTH = 8;
  localparam int DEF_NUM_CLASS = 10;
  localparam int DEF_CLASS_W   = $clog2(DEF_NUM_CLASS);

  typedef logic [DEF_BIT_WIDTH-1:0]   score_t;
  typedef score_t [DEF_NUM_CLASS-1:0] score_vec_t;
  typedef logic [DEF_CLASS_W-1:0]     class_idx_t;

endpackage

// File: rtl/score_max_tracker.sv
// Running max / argmax over the beats of one frame. The combinational
// outputs already include the beat currently presented, so the collector
// can capture the frame result on the final beat without an extra cycle.
// Strict '>' compare: the lowest index wins ties.
import mnist_pkg::*;

module score_max_tracker #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int NUM_CLASS = DEF_NUM_CLASS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         upd,
  input  logic                         first,
  input  logic                         clr,
  input  logic [BIT_WIDTH-1:0]         score,
  input  logic [$clog2(NUM_CLASS)-1:0] idx,
  output logic [BIT_WIDTH-1:0]         nxt_max,
  output logic [$clog2(NUM_CLASS)-1:0] nxt_idx
);

  logic [BIT_WIDTH-1:0]         run_max;
  logic [$clog2(NUM_CLASS)-1:0] run_idx;
  logic                         take;

  // Candidate result: first beat of a frame always replaces the history.
  always_comb begin
    take    = first || (score > run_max);
    nxt_max = take ? score : run_max;
    nxt_idx = take ? idx   : run_idx;
  end

  // Running register; cleared when a misaligned frame is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (clr) begin
      run_max <= '0;
      run_idx <= '0;
    end else if (upd) begin
      run_max <= nxt_max;
      run_idx <= nxt_idx;
    end
  end

endmodule

// File: rtl/score_collector.sv
// Collects NUM_CLASS per-beat class scores into one parallel vector for the
// softmax/max stage. One frame buffer (first NUM_CLASS-1 beats) plus one
// output register, so the next frame fills while the output is stalled.
// Optional feature: define SCORE_COLLECTOR_ARGMAX_EN to add m_argmax/m_max.
import mnist_pkg::*;

module score_collector #(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH,
  parameter int NUM_CLASS = DEF_NUM_CLASS
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                s_valid,
  output logic                                s_ready,
  input  logic [BIT_WIDTH-1:0]                s_score,
  input  logic                                s_last,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [NUM_CLASS-1:0][BIT_WIDTH-1:0] m_scores,
  output logic                                frame_err
`ifdef SCORE_COLLECTOR_ARGMAX_EN
  ,
  output logic [$clog2(NUM_CLASS)-1:0]        m_argmax,
  output logic [BIT_WIDTH-1:0]                m_max
`endif
);

  localparam int               CNT_W    = $clog2(NUM_CLASS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CLASS - 1);

  logic [CNT_W-1:0]                    cnt;
  logic [NUM_CLASS-2:0][BIT_WIDTH-1:0] fbuf;
  logic                                last_beat;
  logic                                accept;
  logic                                drop;
  logic                                done;

  // Handshake decode. Only the final beat depends on the output register.
  // NOTE: every always_comb output gets a value on every path (here by
  // straight-line assignment) so no latch is inferred.
  always_comb begin
    last_beat = (cnt == LAST_IDX);
    s_ready   = !last_beat || !m_valid || m_ready;
    accept    = s_valid && s_ready;
    drop      = accept && s_last && !last_beat;
    done      = accept && last_beat;
  end

  // Beat counter: index of the class expected next.
  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            cnt <= '0;
    else if (drop || done) cnt <= '0;
    else if (accept)       cnt <= cnt + 1'b1;
  end

  // Frame buffer for beats 0..NUM_CLASS-2; the final beat goes straight out.
  // NOTE: this storage is reset because a cleared buffer is part of the
  // defined reset state; a plain data RAM would normally skip it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fbuf <= '0;
    end else if (accept && !last_beat) begin
      for (int i = 0; i < NUM_CLASS - 1; i++)
        if (cnt == CNT_W'(i)) fbuf[i] <= s_score;
    end
  end

  // Output register: loads on frame completion, clears valid on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_scores <= '0;
    end else if (done) begin
      m_valid  <= 1'b1;
      m_scores <= {s_score, fbuf};
    end else if (m_ready) begin
      m_valid  <= 1'b0;
    end
  end

  // Misalignment pulse: early s_last (frame dropped) or missing s_last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_err <= 1'b0;
    else        frame_err <= drop || (done && !s_last);
  end

`ifdef SCORE_COLLECTOR_ARGMAX_EN
  logic [BIT_WIDTH-1:0] trk_max;
  logic [CNT_W-1:0]     trk_idx;

  score_max_tracker #(
    .BIT_WIDTH (BIT_WIDTH),
    .NUM_CLASS (NUM_CLASS)
  ) u_tracker (
    .clk     (clk),
    .rst_n   (rst_n),
    .upd     (accept && !drop),
    .first   (cnt == '0),
    .clr     (drop),
    .score   (s_score),
    .idx     (cnt),
    .nxt_max (trk_max),
    .nxt_idx (trk_idx)
  );

  // Max/argmax registered alongside m_scores with identical hold rules.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_argmax <= '0;
      m_max    <= '0;
    end else if (done) begin
      m_argmax <= trk_idx;
      m_max    <= trk_max;
    end
  end
`endif

endmodule

// File: tb/tb_score_collector.sv
// Scoreboard bench for score_collector (BIT_WIDTH=8, NUM_CLASS=10).
// Stimulus pushes expected vectors; a negedge monitor pops on m_valid&&m_ready.
import mnist_pkg::*;

module tb_score_collector;

  localparam int BW = 8;
  localparam int NC = 10;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic [BW-1:0]      s_score = '0;
  logic               s_last = 1'b0;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic [NC-1:0][BW-1:0] m_scores;
  logic               frame_err;
`ifdef SCORE_COLLECTOR_ARGMAX_EN
  logic [3:0]         m_argmax;
  logic [BW-1:0]      m_max;
`endif

  always #5 clk = ~clk;

  score_collector #(.BIT_WIDTH(BW), .NUM_CLASS(NC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_score   (s_score),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_scores  (m_scores),
    .frame_err (frame_err)
`ifdef SCORE_COLLECTOR_ARGMAX_EN
    ,
    .m_argmax  (m_argmax),
    .m_max     (m_max)
`endif
  );

  typedef struct {
    logic [NC*BW-1:0] scores;
    logic [3:0]       amax;
    logic [BW-1:0]    mx;
  } exp_t;

  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   stall_cnt = 0;
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [NC*BW-1:0] pack(input logic [BW-1:0] sc [NC]);
    logic [NC*BW-1:0] r;
    for (int i = 0; i < NC; i++) r[i*BW +: BW] = sc[i];
    return r;
  endfunction

  // Monitor: compare every delivered vector against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_vector: got %0h expected none", m_scores);
      end else begin
        mon_e = exp_q.pop_front();
        check("m_scores", 128'(m_scores), 128'(mon_e.scores));
`ifdef SCORE_COLLECTOR_ARGMAX_EN
        check("m_argmax", 128'(m_argmax), 128'(mon_e.amax));
        check("m_max", 128'(m_max), 128'(mon_e.mx));
`endif
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic send_beat(input logic [BW-1:0] sc, input logic lst);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_score = sc;
    s_last  = lst;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      n++;
      stall_cnt++;
      @(negedge clk);
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: s_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [BW-1:0] sc [NC], input logic [3:0] amax,
                            input logic [BW-1:0] mx, input logic tag_last, input logic push);
    exp_t e;
    e.scores = pack(sc);
    e.amax   = amax;
    e.mx     = mx;
    if (push) exp_q.push_back(e);
    for (int i = 0; i < NC; i++) send_beat(sc[i], (i == NC - 1) ? tag_last : 1'b0);
  endtask

  logic [BW-1:0] fr [NC];
  logic [BW-1:0] fa [NC];
  logic [BW-1:0] fb [NC];
  int            base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_m_valid", 128'(m_valid), 128'(0));
    check("rst_m_scores", 128'(m_scores), 128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
`ifdef SCORE_COLLECTOR_ARGMAX_EN
    check("rst_m_argmax", 128'(m_argmax), 128'(0));
    check("rst_m_max", 128'(m_max), 128'(0));
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    check("rst_s_ready", 128'(s_ready), 128'(1));

    // 1: basic frame, latency one cycle after final beat
    fr = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    exp_q.push_back('{pack(fr), 4'd9, 8'd100});
    for (int i = 0; i < NC - 1; i++) send_beat(fr[i], 1'b0);
    check("t1_no_early_valid", 128'(m_valid), 128'(0));
    send_beat(fr[NC-1], 1'b1);
    check("t1_valid_after_last", 128'(m_valid), 128'(1));
    check("t1_no_err", 128'(frame_err), 128'(0));
    @(posedge clk); #1;
    check("t1_valid_drops", 128'(m_valid), 128'(0));

    // 2: stalled output, next frame fills, final beat held off
    m_ready = 1'b0;
    fa = '{3, 1, 4, 1, 5, 9, 2, 6, 5, 3};
    send_frame(fa, 4'd5, 8'd9, 1'b1, 1'b1);
    fb = '{200, 40, 30, 20, 10, 0, 60, 70, 80, 90};
    exp_q.push_back('{pack(fb), 4'd0, 8'd200});
    base = stall_cnt;
    for (int i = 0; i < NC - 1; i++) send_beat(fb[i], 1'b0);
    check("t2_nonfinal_no_stall", 128'(stall_cnt - base), 128'(0));
    s_valid = 1'b1; s_score = fb[NC-1]; s_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t2_s_ready_low", 128'(s_ready), 128'(0));
      check("t2_scores_held", 128'(m_scores), 128'(pack(fa)));
    end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    check("t2_s_ready_high", 128'(s_ready), 128'(1));
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    check("t2_b2b_valid", 128'(m_valid), 128'(1));
    check("t2_new_scores", 128'(m_scores), 128'(pack(fb)));
    @(posedge clk); #1;

    // 3: back-to-back frames, one vector every NC cycles
    base = stall_cnt;
    fr = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
    send_frame(fr, 4'd0, 8'd9, 1'b1, 1'b1);
    fr = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_frame(fr, 4'd0, 8'd0, 1'b1, 1'b1);
    fr = '{1, 255, 3, 255, 5, 6, 7, 8, 9, 10};
    send_frame(fr, 4'd1, 8'd255, 1'b1, 1'b1);
    repeat (2) @(posedge clk); #1;
    check("t3_no_stall", 128'(stall_cnt - base), 128'(0));
    if (pop_cyc.size() >= 3) begin
      check("t3_gap_a", 128'(pop_cyc[pop_cyc.size()-2] - pop_cyc[pop_cyc.size()-3]), 128'(NC));
      check("t3_gap_b", 128'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 128'(NC));
    end else begin
      check("t3_pop_count", 128'(pop_cyc.size()), 128'(3));
    end

    // 4: early s_last drops the frame; missing s_last still delivers
    for (int i = 0; i < 4; i++) send_beat(BW'(11 + i), 1'b0);
    send_beat(8'd15, 1'b1);
    check("t4_early_err", 128'(frame_err), 128'(1));
    check("t4_no_valid", 128'(m_valid), 128'(0));
    @(posedge clk); #1;
    check("t4_err_pulse", 128'(frame_err), 128'(0));
    fr = '{12, 34, 56, 78, 90, 21, 43, 65, 87, 9};
    send_frame(fr, 4'd4, 8'd90, 1'b1, 1'b1);
    check("t4_realign_valid", 128'(m_valid), 128'(1));
    fr = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 250};
    send_frame(fr, 4'd9, 8'd250, 1'b0, 1'b1);
    check("t4_missing_last_err", 128'(frame_err), 128'(1));
    check("t4_missing_last_valid", 128'(m_valid), 128'(1));
    @(posedge clk); #1;
    check("t4_err_pulse2", 128'(frame_err), 128'(0));

    // 5: tie on max -> lowest index
    fr = '{7, 7, 7, 200, 7, 7, 200, 7, 7, 7};
    send_frame(fr, 4'd3, 8'd200, 1'b1, 1'b1);
    @(posedge clk); #1;

    // 6a: reset mid-frame discards the partial frame
    for (int i = 0; i < 5; i++) send_beat(BW'(1 + i), 1'b0);
    s_valid = 1'b1; s_score = 8'd6;
    #2 rst_n = 1'b0; s_valid = 1'b0;
    #1;
    check("t6_mid_valid", 128'(m_valid), 128'(0));
    check("t6_mid_s_ready", 128'(s_ready), 128'(1));
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    fr = '{5, 4, 3, 2, 1, 10, 20, 30, 40, 50};
    send_frame(fr, 4'd9, 8'd50, 1'b1, 1'b1);
    check("t6_clean_valid", 128'(m_valid), 128'(1));
    @(posedge clk); #1;

    // 6b: reset while an undelivered vector is held
    m_ready = 1'b0;
    fr = '{90, 91, 92, 93, 94, 95, 96, 97, 98, 99};
    send_frame(fr, 4'd9, 8'd99, 1'b0, 1'b0);
    check("t6_held_valid", 128'(m_valid), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_valid", 128'(m_valid), 128'(0));
    check("t6_async_scores", 128'(m_scores), 128'(0));
    check("t6_async_err", 128'(frame_err), 128'(0));
`ifdef SCORE_COLLECTOR_ARGMAX_EN
    check("t6_async_argmax", 128'(m_argmax), 128'(0));
    check("t6_async_max", 128'(m_max), 128'(0));
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 m_ready = 1'b1;
    fr = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 8};
    send_frame(fr, 4'd8, 8'd9, 1'b1, 1'b1);
    repeat (3) @(posedge clk); #1;

    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
